// File: rtl/arb_pkg.sv
// arb_pkg: shared definitions for the instruction/data memory arbiter.
//   arbStateT       - FSM state encoding (IDLE, SERVE_I, SERVE_D)
//   DEFAULT_TIMEOUT - default wait limit before an access is aborted
//   counterWidth()  - wait counter width: at least 4 bits, wide enough for the limit
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    SERVE_I = 2'b01,
    SERVE_D = 2'b10
  } arbStateT;

  localparam int DEFAULT_TIMEOUT = 15;

  function automatic int counterWidth(input int limit);
    return (limit >= 16) ? $clog2(limit + 1) : 4;
  endfunction

endpackage

// File: rtl/wait_counter.sv
// wait_counter: saturating wait-cycle counter with a terminal-count compare.
// Ports:
//   clk, reset  - clock and asynchronous active-high reset
//   clear       - synchronous clear (takes priority over enable)
//   enable      - count one wait cycle
//   reachLimit  - high when this enabled cycle brings the count up to LIMIT
module wait_counter #(
  parameter int WIDTH = 4,
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic reachLimit
);

  localparam logic [WIDTH-1:0] LastCount = WIDTH'(LIMIT - 1);

  logic [WIDTH-1:0] count;

  // Count stops at all-ones instead of wrapping back to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  // Flag the cycle whose increment lands on LIMIT so the abort happens on that same edge.
  assign reachLimit = enable && (count == LastCount);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates fetch and memory-stage requests onto one
// single-port unified memory.
// Ports:
//   clk, reset                  - clock, asynchronous active-high reset
//   IReq, IAddr                 - instruction read request
//   DReq, DWe, DAddr, DWData    - data access request
//   MemReq, MemWe, MemAddr,
//   MemWData, MemRData, MemReady - memory side handshake
//   IRData, IValid              - returned instruction and its one-cycle pulse
//   DRData, DValid              - returned load data / write-done pulse
//   StallF, StallM              - hold signals for fetch and memory stage
//   TimeoutErr                  - sticky flag: an access waited TIMEOUT cycles
// Config macro: ARB_ROUND_ROBIN_EN selects round-robin on simultaneous
// requests; otherwise data always wins.
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IReq,
  input  logic [31:0] IAddr,
  input  logic        DReq,
  input  logic        DWe,
  input  logic [31:0] DAddr,
  input  logic [31:0] DWData,
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  input  logic [31:0] MemRData,
  input  logic        MemReady,
  output logic [31:0] IRData,
  output logic        IValid,
  output logic [31:0] DRData,
  output logic        DValid,
  output logic        StallF,
  output logic        StallM,
  output logic        TimeoutErr
);

  localparam int countWidth = counterWidth(TIMEOUT);

  arbStateT state;
  arbStateT nextState;
  logic     pickData;
  logic     grant;
  logic     weReg;
  logic     waitEnable;
  logic     timeoutHit;

`ifdef ARB_ROUND_ROBIN_EN
  logic lastGrantData;

  // Remembers which port won the most recent grant; starts out as fetch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lastGrantData <= 1'b0;
    end else if (grant) begin
      lastGrantData <= pickData;
    end
  end

  assign pickData = DReq && !(IReq && lastGrantData);
`else
  assign pickData = DReq;
`endif

  assign grant      = (state == IDLE) && (IReq || DReq);
  assign waitEnable = MemReq && !MemReady;

  wait_counter #(
    .WIDTH(countWidth),
    .LIMIT(TIMEOUT)
  ) waitCounter (
    .clk       (clk),
    .reset     (reset),
    .clear     (grant),
    .enable    (waitEnable),
    .reachLimit(timeoutHit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (pickData) begin
          nextState = SERVE_D;
        end else if (IReq) begin
          nextState = SERVE_I;
        end
      end
      SERVE_I, SERVE_D: begin
        if (MemReady || timeoutHit) begin
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // The write strobe is gated by MemReq so a stale write flag never leaks out while idle.
  always_comb begin
    MemReq = (state != IDLE);
    MemWe  = MemReq && weReg;
  end

  // Request fields are captured at grant so memory sees stable values even
  // if the requester changes or drops its inputs mid-access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      MemAddr    <= '0;
      MemWData   <= '0;
      weReg      <= 1'b0;
      IRData     <= '0;
      DRData     <= '0;
      IValid     <= 1'b0;
      DValid     <= 1'b0;
      TimeoutErr <= 1'b0;
    end else begin
      IValid <= 1'b0;
      DValid <= 1'b0;
      if (grant) begin
        if (pickData) begin
          MemAddr  <= DAddr;
          MemWData <= DWData;
          weReg    <= DWe;
        end else begin
          MemAddr <= IAddr;
          weReg   <= 1'b0;
        end
      end
      if ((state == SERVE_I) && MemReady) begin
        IRData <= MemRData;
        IValid <= 1'b1;
      end
      if ((state == SERVE_D) && MemReady) begin
        DValid <= 1'b1;
        if (!weReg) begin
          DRData <= MemRData;
        end
      end
      if (timeoutHit) begin
        TimeoutErr <= 1'b1;
      end
    end
  end

  assign StallF = IReq && !IValid;
  assign StallM = DReq && !DValid;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed literal checks followed by randomized traffic,
// compared every cycle against a transaction-level model of the arbiter.
// Honors ARB_ROUND_ROBIN_EN in the model when the design is built with it.
module tb_mem_arbiter;

  localparam int TIMEOUT_TB = 15;

  logic        clk;
  logic        reset;
  logic        IReq;
  logic [31:0] IAddr;
  logic        DReq;
  logic        DWe;
  logic [31:0] DAddr;
  logic [31:0] DWData;
  logic        MemReq;
  logic        MemWe;
  logic [31:0] MemAddr;
  logic [31:0] MemWData;
  logic [31:0] MemRData;
  logic        MemReady;
  logic [31:0] IRData;
  logic        IValid;
  logic [31:0] DRData;
  logic        DValid;
  logic        StallF;
  logic        StallM;
  logic        TimeoutErr;

  int total = 0;
  int bad   = 0;

  mem_arbiter #(.TIMEOUT(TIMEOUT_TB)) dut (
    .clk       (clk),
    .reset     (reset),
    .IReq      (IReq),
    .IAddr     (IAddr),
    .DReq      (DReq),
    .DWe       (DWe),
    .DAddr     (DAddr),
    .DWData    (DWData),
    .MemReq    (MemReq),
    .MemWe     (MemWe),
    .MemAddr   (MemAddr),
    .MemWData  (MemWData),
    .MemRData  (MemRData),
    .MemReady  (MemReady),
    .IRData    (IRData),
    .IValid    (IValid),
    .DRData    (DRData),
    .DValid    (DValid),
    .StallF    (StallF),
    .StallM    (StallM),
    .TimeoutErr(TimeoutErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one outstanding access described by its owner, fields and age.
  bit          accActive = 0;
  bit          accIsData = 0;
  bit          accWe     = 0;
  int          accAge    = 0;
  bit          lastWasData = 0;
  logic [31:0] expAddr   = '0;
  logic [31:0] expWData  = '0;
  logic [31:0] expIRData = '0;
  logic [31:0] expDRData = '0;
  bit          expIValid = 0;
  bit          expDValid = 0;
  bit          expErr    = 0;

  task automatic modelReset();
    accActive = 0; accIsData = 0; accWe = 0; accAge = 0; lastWasData = 0;
    expAddr = '0; expWData = '0; expIRData = '0; expDRData = '0;
    expIValid = 0; expDValid = 0; expErr = 0;
  endtask

  task automatic modelStep();
    bit takeData;
    expIValid = 0;
    expDValid = 0;
    if (accActive) begin
      if (MemReady) begin
        if (accIsData) begin
          expDValid = 1;
          if (!accWe) expDRData = MemRData;
        end else begin
          expIValid = 1;
          expIRData = MemRData;
        end
        accActive = 0;
      end else begin
        accAge++;
        if (accAge == TIMEOUT_TB) begin
          expErr    = 1;
          accActive = 0;
        end
      end
    end else if (IReq || DReq) begin
`ifdef ARB_ROUND_ROBIN_EN
      takeData = (IReq && DReq) ? !lastWasData : DReq;
`else
      takeData = DReq;
`endif
      accActive   = 1;
      accIsData   = takeData;
      accAge      = 0;
      lastWasData = takeData;
      if (takeData) begin
        expAddr  = DAddr;
        expWData = DWData;
        accWe    = DWe;
      end else begin
        expAddr = IAddr;
        accWe   = 0;
      end
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) modelReset();
    else modelStep();
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  // Continuous comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    checkOutput("MemReq",     {31'd0, MemReq},     {31'd0, accActive});
    checkOutput("MemWe",      {31'd0, MemWe},      {31'd0, accActive && accWe});
    checkOutput("MemAddr",    MemAddr,             expAddr);
    checkOutput("MemWData",   MemWData,            expWData);
    checkOutput("IValid",     {31'd0, IValid},     {31'd0, expIValid});
    checkOutput("DValid",     {31'd0, DValid},     {31'd0, expDValid});
    checkOutput("IRData",     IRData,              expIRData);
    checkOutput("DRData",     DRData,              expDRData);
    checkOutput("TimeoutErr", {31'd0, TimeoutErr}, {31'd0, expErr});
    checkOutput("StallF",     {31'd0, StallF},     {31'd0, IReq && !expIValid});
    checkOutput("StallM",     {31'd0, StallM},     {31'd0, DReq && !expDValid});
  end

  task automatic applyStimulus(input logic iReq, input logic [31:0] iAddr,
                               input logic dReq, input logic dWe,
                               input logic [31:0] dAddr, input logic [31:0] dWData,
                               input logic memReady, input logic [31:0] memRData);
    IReq = iReq; IAddr = iAddr; DReq = dReq; DWe = dWe;
    DAddr = dAddr; DWData = dWData; MemReady = memReady; MemRData = memRData;
  endtask

  bit slowWindow;

  initial begin
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    checkOutput("rstMemReq",  {31'd0, MemReq},     32'd0);
    checkOutput("rstMemAddr", MemAddr,             32'd0);
    checkOutput("rstIRData",  IRData,              32'd0);
    checkOutput("rstErr",     {31'd0, TimeoutErr}, 32'd0);

    // Single fetch, memory ready on the first MemReq cycle
    @(posedge clk); #1;
    applyStimulus(1, 32'h10, 0, 0, 0, 0, 1, 32'hCAFE0001);
    @(negedge clk);
    checkOutput("fetchStallF0", {31'd0, StallF}, 32'd1);
    @(negedge clk);
    checkOutput("fetchMemReq",  {31'd0, MemReq}, 32'd1);
    checkOutput("fetchMemAddr", MemAddr,         32'h10);
    checkOutput("fetchStallF1", {31'd0, StallF}, 32'd1);
    @(posedge clk); #1;
    IReq = 0;
    @(negedge clk);
    checkOutput("fetchIValid", {31'd0, IValid}, 32'd1);
    checkOutput("fetchIRData", IRData,          32'hCAFE0001);

    // Data write with MemReady delayed three cycles
    @(posedge clk); #1;
    applyStimulus(0, 0, 1, 1, 32'h200, 32'hDEADBEEF, 0, 32'h12345678);
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      if (c == 4) begin
        MemReady = 1;
        DReq     = 0;
      end
      @(negedge clk);
      checkOutput("wrMemWe",    {31'd0, MemWe}, 32'd1);
      checkOutput("wrMemWData", MemWData,       32'hDEADBEEF);
      checkOutput("wrMemAddr",  MemAddr,        32'h200);
    end
    @(posedge clk); #1;
    MemReady = 0;
    @(negedge clk);
    checkOutput("wrDValid", {31'd0, DValid}, 32'd1);
    checkOutput("wrDRData", DRData,          32'd0);

    // Memory never ready: abort after 15 MemReq cycles
    @(posedge clk); #1;
    applyStimulus(0, 0, 1, 0, 32'h300, 0, 0, 32'h55AA55AA);
    @(posedge clk); #1;
    DReq = 0;
    repeat (15) @(negedge clk);
    checkOutput("toMemReqLast", {31'd0, MemReq},     32'd1);
    checkOutput("toErrBefore",  {31'd0, TimeoutErr}, 32'd0);
    @(negedge clk);
    checkOutput("toMemReqOff",  {31'd0, MemReq},     32'd0);
    checkOutput("toErrSet",     {31'd0, TimeoutErr}, 32'd1);
    checkOutput("toNoDValid",   {31'd0, DValid},     32'd0);

    // Reset in the middle of a data access
    @(posedge clk); #1;
    applyStimulus(0, 0, 1, 0, 32'h400, 0, 0, 0);
    @(posedge clk); #1;
    DReq = 0;
    checkOutput("rsMemReqBefore", {31'd0, MemReq}, 32'd1);
    #2 reset = 1'b1;
    #1;
    checkOutput("rsMemReqNow", {31'd0, MemReq},     32'd0);
    checkOutput("rsErrClear",  {31'd0, TimeoutErr}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("rsNoDValid", {31'd0, DValid}, 32'd0);
    end

    // Simultaneous requests just after reset: data first in both arbitration modes
    @(posedge clk); #1;
    applyStimulus(1, 32'h20, 1, 0, 32'h100, 0, 1, 32'hA5A5A5A5);
    @(posedge clk); #1;
    DReq = 0;
    @(negedge clk);
    checkOutput("bothFirstAddr", MemAddr, 32'h100);
    @(negedge clk);
    checkOutput("bothDValid",  {31'd0, DValid}, 32'd1);
    checkOutput("bothStallF",  {31'd0, StallF}, 32'd1);
    @(negedge clk);
    checkOutput("bothSecondAddr", MemAddr, 32'h20);
    @(posedge clk); #1;
    IReq = 0;
    @(negedge clk);
    checkOutput("bothIValid", {31'd0, IValid}, 32'd1);

    // Randomized traffic with occasional slow windows and reset pulses
    slowWindow = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      if (cyc % 64 == 0) slowWindow = ($urandom_range(0, 3) == 0);
      reset = (cyc % 700 == 350);
      applyStimulus($urandom_range(0, 9) < 6, $urandom(),
                    $urandom_range(0, 9) < 4, $urandom_range(0, 1) == 1,
                    $urandom(), $urandom(),
                    slowWindow ? ($urandom_range(0, 99) < 2) : ($urandom_range(0, 1) == 1),
                    $urandom());
    end
    @(posedge clk); #1;
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum cycles a granted access may wait for MemReady before the error flag is raised.
REQ-002 clk  input  1  single clock for the arbiter; all state changes on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 IReq  input  1  fetch stage requests an instruction read.
REQ-005 IAddr  input  32  fetch address.
REQ-006 DReq  input  1  memory stage requests a data access.
REQ-007 DWe  input  1  data access is a write (MemWriteM).
REQ-008 DAddr  input  32  data address.
REQ-009 DWData  input  32  data write value.
REQ-010 MemReq  output  1  request to the single-port unified memory.
REQ-011 MemWe  output  1  write strobe to memory.
REQ-012 MemAddr  output  32  memory address.
REQ-013 MemWData  output  32  memory write data.
REQ-014 MemRData  input  32  memory read data, valid when MemReady=1.
REQ-015 MemReady  input  1  memory completes the current access this cycle.
REQ-016 IRData  output  32  instruction returned to fetch.
REQ-017 IValid  output  1  one-cycle pulse: IRData valid.
REQ-018 DRData  output  32  load data returned to the memory stage.
REQ-019 DValid  output  1  one-cycle pulse: DRData valid or write done.
REQ-020 StallF  output  1  fetch must hold (IReq=1 and no IValid this cycle).
REQ-021 StallM  output  1  memory stage must hold (DReq=1 and no DValid this cycle).
REQ-022 TimeoutErr  output  1  sticky: a granted access exceeded TIMEOUT cycles.

Function
REQ-023 FSM states: IDLE, SERVE_I, SERVE_D.
REQ-024 IDLE: DReq=1 goes to SERVE_D; else IReq=1 goes to SERVE_I; else stays in IDLE.
REQ-025 Fixed priority: data beats fetch when both request in the same cycle.
REQ-026 On grant, the address, write data and write enable are latched into registers; MemReq asserts the following cycle and holds until MemReady.
REQ-027 MemAddr, MemWData and MemWe stay stable while MemReq=1.
REQ-028 MemReady=1 in SERVE_I: IRData<=MemRData and IValid pulses for one cycle.
REQ-029 MemReady=1 in SERVE_D: DRData<=MemRData (reads only; unchanged for writes) and DValid pulses for one cycle.
REQ-030 On completion the FSM returns to IDLE; minimum request-to-valid latency is 2 cycles (grant, then MemReady in the first MemReq cycle).
REQ-031 MemReady while in IDLE is ignored.
REQ-032 Requester deasserting its request mid-access: the access still completes and the valid pulse is still issued.
REQ-033 Wait counter: 4-bit minimum width, cleared on grant, increments each MemReq cycle without MemReady, saturates.
REQ-034 When the counter reaches TIMEOUT, TimeoutErr sets, the access aborts (no valid pulse) and the FSM returns to IDLE.
REQ-035 StallF and StallM are combinational from the request inputs and the valid pulses.

Reset
REQ-036 Reset forces IDLE, clears the counter, and drives MemReq, MemWe, IValid, DValid and TimeoutErr to 0 and MemAddr, MemWData, IRData and DRData to 0.
REQ-037 Reset asserted mid-access abandons the access immediately; no valid pulse follows reset release.
REQ-038 TimeoutErr clears only on reset.

Configuration
REQ-039 Macro ARB_ROUND_ROBIN_EN: when defined, on simultaneous IReq and DReq in IDLE the grant goes to the port not served last; a 1-bit last-grant register is added and reset to "fetch".
REQ-040 Without ARB_ROUND_ROBIN_EN, the fixed data-first priority of REQ-025 applies and the last-grant register does not exist.

Structure
REQ-041 Shared package arb_pkg holds the FSM state encoding (IDLE=2'b00, SERVE_I=2'b01, SERVE_D=2'b10) and the default TIMEOUT constant.
REQ-042 One sub-module, wait_counter (clear, enable, saturating count, terminal-count compare), is instantiated once.

Verification
REQ-043 IReq=1, IAddr=0x00000010, MemReady asserted on the first MemReq cycle -> MemAddr=0x10, IValid pulses at cycle 2 with IRData=MemRData, StallF=1 until then.
REQ-044 IReq=DReq=1, DAddr=0x100 -> data is served first (DValid), fetch follows; with ARB_ROUND_ROBIN_EN and last grant = data, fetch is served first.
REQ-045 DReq=1, DWe=1, DWData=0xDEADBEEF, MemReady delayed 3 cycles -> MemWe=1 and MemWData held stable for 4 cycles, DValid pulses once, DRData unchanged.
REQ-046 MemReady held 0 with TIMEOUT=15 -> TimeoutErr=1 after 15 MemReq cycles, FSM in IDLE, no valid pulse.
REQ-047 Reset asserted during SERVE_D with MemReq=1 -> MemReq=0 immediately, state IDLE, no DValid after release.
